// File: rtl/piso_serial_tx_pkg.sv
// rtl/piso_serial_tx_pkg.sv - shared serial link definitions: state encodings, default word size, output record
package piso_serial_tx_pkg;

    // Word size and bit order shared by both ends of the serial link.
    localparam int DEFAULT_WIDTH     = 8;
    localparam bit DEFAULT_MSB_FIRST = 1'b1;

    // FSM encodings kept as plain constants so the receiver can reuse them verbatim.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Registered serial outputs travel together so they always update on the same edge.
    typedef struct packed {
        logic sdo;
        logic valid;
        logic last;
    } tx_out_t;

    // Bit counter width: enough to index WIDTH bits, never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/tx_bit_counter.sv
// rtl/tx_bit_counter.sv - index of the bit currently on the line, with last/next-last flags
module tx_bit_counter
    import piso_serial_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic is_last,
    output logic next_is_last
);

    localparam int            CW         = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT_IDX = CW'((WIDTH > 1) ? (WIDTH - 2) : 0);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Clear wins over enable so a new word always starts at index 0; saturate at the last index.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !is_last) begin
            count_d = count_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign is_last      = (count_q == LAST_IDX);
    // For a one-bit word there is no second-to-last bit; the first bit is already the last.
    assign next_is_last = (WIDTH > 1) && (count_q == PENULT_IDX);

endmodule

// File: rtl/piso_serial_tx.sv
// rtl/piso_serial_tx.sv - parallel-in serial-out transmitter with valid/ready load and last-bit marker
module piso_serial_tx
    import piso_serial_tx_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = DEFAULT_MSB_FIRST
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             sdo_last
);

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    tx_out_t          out_q;
    tx_out_t          out_d;

    logic accept;
    logic advance;
    logic cnt_is_last;
    logic cnt_next_is_last;

    // Bit that goes on the line next, taken from the end selected by the bit order.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Remaining bits after the head bit has been sent; vacated positions fill with zero.
    function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // A new word may enter when nothing is in flight or the final bit is on the line now,
    // which lets words follow each other with no idle cycle.
    assign load_ready = !reset && ((state_q == ST_IDLE) || out_q.last);
    assign accept     = load_valid && load_ready;
    // Mid-word: another bit of the current word still has to be shown.
    assign advance    = (state_q == ST_SHIFT) && !cnt_is_last;

    tx_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk          (clk),
        .reset        (reset),
        .clear        (accept),
        .enable       (advance),
        .is_last      (cnt_is_last),
        .next_is_last (cnt_next_is_last)
    );

    // Next state, shift register and line outputs; anything not loading or shifting idles low.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        out_d   = '0;
        if (accept) begin
            state_d     = ST_SHIFT;
            out_d.sdo   = head_bit(load_data);
            out_d.valid = 1'b1;
            out_d.last  = (WIDTH == 1);
            shreg_d     = drop_head(load_data);
        end else if (advance) begin
            out_d.sdo   = head_bit(shreg_q);
            out_d.valid = 1'b1;
            out_d.last  = cnt_next_is_last;
            shreg_d     = drop_head(shreg_q);
        end else begin
            state_d = ST_IDLE;
            shreg_d = '0;
        end
    end

    // State, shift register and output registers; reset drops the line at once and
    // discards any partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            out_q   <= out_d;
        end
    end

    assign sdo       = out_q.sdo;
    assign sdo_valid = out_q.valid;
    assign sdo_last  = out_q.last;

endmodule

// File: tb/tb_piso_serial_tx.sv
// tb/tb_piso_serial_tx.sv - self-checking bench for piso_serial_tx (tables, corner sequences, random vs model)
module tb_piso_serial_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       lv_a, lr_a, sdo_a, sv_a, sl_a;
    logic [7:0] ld_a;
    logic       lv_b, lr_b, sdo_b, sv_b, sl_b;
    logic [7:0] ld_b;
    logic       lv_c, lr_c, sdo_c, sv_c, sl_c;
    logic [0:0] ld_c;

    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .reset(reset), .load_valid(lv_a), .load_ready(lr_a), .load_data(ld_a),
        .sdo(sdo_a), .sdo_valid(sv_a), .sdo_last(sl_a));

    piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset), .load_valid(lv_b), .load_ready(lr_b), .load_data(ld_b),
        .sdo(sdo_b), .sdo_valid(sv_b), .sdo_last(sl_b));

    piso_serial_tx #(.WIDTH(1), .MSB_FIRST(1'b1)) dut_c (
        .clk(clk), .reset(reset), .load_valid(lv_c), .load_ready(lr_c), .load_data(ld_c),
        .sdo(sdo_c), .sdo_valid(sv_c), .sdo_last(sl_c));

    int checks = 0;
    int errors = 0;

    // Reference model for dut_a: the bit on the line now, plus the bits of the word still to come.
    logic mq[$];
    logic m_valid, m_bit, m_last;

    logic [31:0] cap;
    int          cap_n;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       e_sdo;
        logic       e_val;
        logic       e_last;
        logic       e_rdy;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic m_ready();
        return !reset && (!m_valid || m_last);
    endfunction

    task automatic m_reset();
        mq.delete();
        m_valid = 1'b0;
        m_bit   = 1'b0;
        m_last  = 1'b0;
    endtask

    // One clock of the model: an accepted word queues its 8 bits MSB first, then one bit is shown.
    task automatic m_step(input logic acc, input logic [7:0] d);
        if (acc) begin
            for (int i = 7; i >= 0; i--) mq.push_back(d[i]);
        end
        if (mq.size() > 0) begin
            m_bit   = mq.pop_front();
            m_valid = 1'b1;
            m_last  = (mq.size() == 0);
        end else begin
            m_bit   = 1'b0;
            m_valid = 1'b0;
            m_last  = 1'b0;
        end
    endtask

    // One cycle on dut_a: drive, compare against the model mid-cycle, advance the model at the edge.
    task automatic cyc_a(input logic v, input logic [7:0] d);
        logic acc;
        lv_a = v;
        ld_a = d;
        @(negedge clk);
        chk("a_ready", lr_a, m_ready());
        chk("a_valid", sv_a, m_valid);
        chk("a_sdo", sdo_a, m_bit);
        chk("a_last", sl_a, m_last);
        if (sv_a) begin
            cap = {cap[30:0], sdo_a};
            cap_n++;
        end
        acc = v && m_ready();
        @(posedge clk);
        m_step(acc, d);
        #1;
    endtask

    task automatic run_b(input logic [7:0] d);
        lv_b = 1'b1;
        ld_b = d;
        @(negedge clk);
        chk("b_ready", lr_b, 1);
        @(posedge clk);
        #1;
        lv_b = 1'b0;
        ld_b = ~d;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("b_sdo%0d", i), sdo_b, d[i]);
            chk("b_valid", sv_b, 1);
            chk("b_last", sl_b, (i == 7) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("b_idle_valid", sv_b, 0);
        chk("b_idle_sdo", sdo_b, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] a5;
        logic       prev_c;
        logic       acc;
        logic       v;
        logic [7:0] d;

        reset = 1'b1;
        lv_a = 1'b0; ld_a = '0;
        lv_b = 1'b0; ld_b = '0;
        lv_c = 1'b0; ld_c = '0;
        m_reset();
        cap = '0; cap_n = 0;

        // Reset state
        #10;
        chk("rst_ready_a", lr_a, 0);
        chk("rst_valid_a", sv_a, 0);
        #10;
        reset = 1'b0;
        #1;
        chk("rel_sdo_a", sdo_a, 0);
        chk("rel_valid_a", sv_a, 0);
        chk("rel_last_a", sl_a, 0);
        chk("rel_ready_a", lr_a, 1);
        chk("rel_ready_c", lr_c, 1);
        @(posedge clk);
        #1;

        // Single word 8'hA5, MSB first
        a5 = 8'hA5;
        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{1'b0, 8'h00, a5[8-i], 1'b1, (i == 8), (i == 8)};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            lv_a = tbl[i].v;
            ld_a = tbl[i].d;
            @(negedge clk);
            chk($sformatf("tbl%0d_sdo", i), sdo_a, tbl[i].e_sdo);
            chk($sformatf("tbl%0d_valid", i), sv_a, tbl[i].e_val);
            chk($sformatf("tbl%0d_last", i), sl_a, tbl[i].e_last);
            chk($sformatf("tbl%0d_ready", i), lr_a, tbl[i].e_rdy);
            acc = tbl[i].v && m_ready();
            @(posedge clk);
            m_step(acc, tbl[i].d);
            #1;
        end

        // Back-to-back: 3C accepted on A5's last bit, no gap
        cap = '0; cap_n = 0;
        cyc_a(1'b1, 8'hA5);
        repeat (8) cyc_a(1'b1, 8'h3C);
        repeat (9) cyc_a(1'b0, 8'h00);
        chk("b2b_count", cap_n, 16);
        chk("b2b_bits", cap[15:0], 16'hA53C);

        // Load attempt mid-word is ignored until the last-bit cycle
        cap = '0; cap_n = 0;
        cyc_a(1'b1, 8'hA5);
        repeat (3) cyc_a(1'b0, 8'h00);
        repeat (5) cyc_a(1'b1, 8'hFF);
        repeat (9) cyc_a(1'b0, 8'h00);
        chk("busy_count", cap_n, 16);
        chk("busy_bits", cap[15:0], 16'hA5FF);

        // Reset mid-word clears outputs immediately; next word is clean
        cyc_a(1'b1, 8'hA5);
        repeat (3) cyc_a(1'b0, 8'h00);
        chk("mid_valid", sv_a, 1);
        reset = 1'b1;
        #1;
        chk("arst_valid", sv_a, 0);
        chk("arst_sdo", sdo_a, 0);
        chk("arst_last", sl_a, 0);
        chk("arst_ready", lr_a, 0);
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cap = '0; cap_n = 0;
        cyc_a(1'b1, 8'h0F);
        repeat (9) cyc_a(1'b0, 8'h00);
        chk("post_rst_count", cap_n, 8);
        chk("post_rst_bits", cap[7:0], 8'h0F);

        // LSB first
        run_b(8'h01);
        run_b(8'($urandom));

        // WIDTH=1: continuous load_valid, one word per clock
        lv_c = 1'b1;
        prev_c = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ld_c = 1'($urandom);
            @(negedge clk);
            chk("c_ready", lr_c, 1);
            if (i == 0) begin
                chk("c_first_valid", sv_c, 0);
            end else begin
                chk("c_valid", sv_c, 1);
                chk("c_last", sl_c, 1);
                chk("c_sdo", sdo_c, prev_c);
            end
            prev_c = ld_c;
            @(posedge clk);
            #1;
        end
        lv_c = 1'b0;
        @(negedge clk);
        chk("c_tail_valid", sv_c, 1);
        chk("c_tail_sdo", sdo_c, prev_c);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("c_idle_valid", sv_c, 0);
        @(posedge clk);
        #1;

        // Random traffic on dut_a against the model
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            cyc_a(v, d);
        end
        repeat (10) cyc_a(1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
